// File: rtl/feistel_round_ctrl.sv
// Round sequencer for a 16+16-bit Feistel block: latches L/R, iterates ROUNDS
// rounds through an external F unit over req/ack, and presents the final-swapped result.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// RUN   | f_req held high, one Feistel round completes per f_ack
// DONE  | single-cycle done pulse, dout_* freshly loaded
module feistel_round_ctrl #(
  parameter int ROUNDS = 8,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic [15:0]      din_left,
  input  logic [15:0]      din_right,
  output logic             ready,
  output logic             f_req,
  output logic [15:0]      f_data,
  output logic [IDX_W-1:0] f_key_idx,
  input  logic             f_ack,
  input  logic [15:0]      f_result,
  output logic [15:0]      dout_left,
  output logic [15:0]      dout_right,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] LAST_RND = (IDX_W+1)'(ROUNDS - 1);
  localparam logic [IDX_W:0] RND_ONE  = (IDX_W+1)'(1);

  state_t           state_q;
  logic [15:0]      l_q, r_q;
  logic [IDX_W:0]   rnd_q;
  logic             mode_q;
  logic             ready_q, f_req_q, done_q;
  logic [15:0]      f_data_q, dout_left_q, dout_right_q;
  logic [IDX_W-1:0] key_q;

  logic [15:0]      r_next;
  logic [IDX_W:0]   rnd_next;

  // Decrypt walks the key schedule backwards so the same datapath inverts the cipher.
  function automatic logic [IDX_W-1:0] key_idx(input logic dec, input logic [IDX_W:0] r);
    return dec ? IDX_W'(LAST_RND - r) : IDX_W'(r);
  endfunction

  assign r_next   = l_q ^ f_result;
  assign rnd_next = rnd_q + RND_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      l_q          <= '0;
      r_q          <= '0;
      rnd_q        <= '0;
      mode_q       <= 1'b0;
      ready_q      <= 1'b1;
      f_req_q      <= 1'b0;
      done_q       <= 1'b0;
      f_data_q     <= '0;
      key_q        <= '0;
      dout_left_q  <= '0;
      dout_right_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            l_q      <= din_left;
            r_q      <= din_right;
            mode_q   <= decrypt;
            rnd_q    <= '0;
            ready_q  <= 1'b0;
            f_req_q  <= 1'b1;
            f_data_q <= din_right;
            key_q    <= key_idx(decrypt, '0);
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (f_ack) begin
            l_q      <= r_q;
            r_q      <= r_next;
            rnd_q    <= rnd_next;
            f_data_q <= r_next;
            if (rnd_q == LAST_RND) begin
              // Output halves swapped back so the last round's swap is undone.
              f_req_q      <= 1'b0;
              done_q       <= 1'b1;
              dout_left_q  <= r_next;
              dout_right_q <= r_q;
              state_q      <= DONE;
            end else begin
              key_q <= key_idx(mode_q, rnd_next);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          f_req_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign f_req      = f_req_q;
  assign f_data     = f_data_q;
  assign f_key_idx  = key_q;
  assign dout_left  = dout_left_q;
  assign dout_right = dout_right_q;
  assign done       = done_q;

endmodule

// File: tb/tb_feistel_round_ctrl.sv
// Directed self-checking bench for feistel_round_ctrl (ROUNDS=8).
module tb_feistel_round_ctrl;
  localparam int ROUNDS = 8;
  localparam int IDX_W  = 3;

  logic             clk, rst, start, decrypt, f_ack;
  logic [15:0]      din_left, din_right, f_result;
  logic             ready, f_req, done;
  logic [15:0]      f_data, dout_left, dout_right;
  logic [IDX_W-1:0] f_key_idx;

  int errors = 0;
  int checks = 0;

  logic [IDX_W-1:0] obs_key[$];
  logic [15:0]      obs_fdata[$];
  int               done_cyc, done_cnt, ready_cyc;
  logic [15:0]      res_l, res_r;
  bit               unstable, timeout;
  logic             rs_ready, rs_freq, rs_done;
  logic [15:0]      rs_dl, rs_dr;

  feistel_round_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .din_left(din_left), .din_right(din_right), .ready(ready),
    .f_req(f_req), .f_data(f_data), .f_key_idx(f_key_idx),
    .f_ack(f_ack), .f_result(f_result), .dout_left(dout_left),
    .dout_right(dout_right), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f_fn(input int fmode, input logic [15:0] d,
                                       input logic [IDX_W-1:0] k);
    logic [31:0] p;
    if (fmode == 0) return 16'h0000;
    p = d * 32'h9E37 + 32'h1111 * k;
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref_cipher(input bit dec, input logic [15:0] l0,
                                             input logic [15:0] r0, input int fmode);
    logic [15:0] l, r, t;
    logic [IDX_W-1:0] idx;
    int ii;
    l = l0; r = r0;
    for (int k = 0; k < ROUNDS; k++) begin
      ii  = dec ? (ROUNDS - 1 - k) : k;
      idx = ii[IDX_W-1:0];
      t = r;
      r = l ^ f_fn(fmode, r, idx);
      l = t;
    end
    return {r, l};
  endfunction

  // Runs one operation from a negedge; records observations, makes no comparisons.
  task automatic drive_op(input bit dec, input logic [15:0] l, input logic [15:0] r,
                          input int fmode, input int wait_n, input int busy_at,
                          input int rst_at);
    int wcnt;
    logic [15:0] ref_d;
    logic [IDX_W-1:0] ref_k;
    obs_key.delete(); obs_fdata.delete();
    done_cnt = 0; done_cyc = -1; ready_cyc = -1; unstable = 0; timeout = 0;
    wcnt = 0; ref_d = '0; ref_k = '0;
    start = 1'b1; decrypt = dec; din_left = l; din_right = r;
    f_ack = (wait_n == 0); f_result = 16'h0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (rst_at > 0 && c == rst_at + 1) begin
        rs_ready = ready; rs_freq = f_req; rs_done = done;
        rs_dl = dout_left; rs_dr = dout_right;
        rst = 1'b0;
        return;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c; res_l = dout_left; res_r = dout_right;
        end
      end
      if (done_cyc >= 0 && c > done_cyc && ready === 1'b1 && ready_cyc < 0) ready_cyc = c;
      if (ready_cyc >= 0 && c >= ready_cyc + 3) return;
      start = (c == busy_at);
      if (c == busy_at) begin
        din_left = 16'hFFFF; din_right = 16'hFFFF; decrypt = ~dec;
      end
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (f_req === 1'b1) begin
        if (wcnt == 0) begin
          ref_d = f_data; ref_k = f_key_idx;
        end else if (f_data !== ref_d || f_key_idx !== ref_k) begin
          unstable = 1;
        end
        if (wcnt == wait_n) begin
          f_ack = 1'b1;
          f_result = f_fn(fmode, f_data, f_key_idx);
          obs_key.push_back(f_key_idx);
          obs_fdata.push_back(f_data);
          wcnt = 0;
        end else begin
          f_ack = 1'b0;
          f_result = 16'($urandom);
          wcnt++;
        end
      end else begin
        f_ack = (wait_n == 0);
        f_result = (wait_n == 0) ? 16'h0 : 16'($urandom);
        wcnt = 0;
      end
      @(negedge clk);
    end
    timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; din_left = 16'h5555; din_right = 16'hAAAA;
    f_ack = 1'b1; f_result = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (f_req !== 1'b0) begin errors++; $display("FAIL reset_f_req: got %b expected 0", f_req); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (f_data !== 16'h0) begin errors++; $display("FAIL reset_f_data: got %h expected 0000", f_data); end
    checks++; if (f_key_idx !== 3'd0) begin errors++; $display("FAIL reset_key: got %0d expected 0", f_key_idx); end
    checks++; if (dout_left !== 16'h0 || dout_right !== 16'h0) begin
      errors++; $display("FAIL reset_dout: got %h/%h expected 0000/0000", dout_left, dout_right);
    end
    rst = 1'b0; f_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_null_f();
    drive_op(1'b0, 16'h1234, 16'hABCD, 0, 0, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL null_timeout: got timeout expected done"); end
    checks++; if (done_cyc != 9) begin errors++; $display("FAIL null_done_cycle: got %0d expected 9", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL null_done_count: got %0d expected 1", done_cnt); end
    checks++; if (ready_cyc != 10) begin errors++; $display("FAIL null_ready_cycle: got %0d expected 10", ready_cyc); end
    checks++; if (res_l !== 16'hABCD || res_r !== 16'h1234) begin
      errors++; $display("FAIL null_result: got %h/%h expected abcd/1234", res_l, res_r);
    end
    checks++; if (dout_left !== 16'hABCD || dout_right !== 16'h1234) begin
      errors++; $display("FAIL null_hold: got %h/%h expected abcd/1234", dout_left, dout_right);
    end
  endtask

  task automatic test_key_order();
    logic [15:0] l, r, t;
    logic [IDX_W-1:0] ek;
    int ii;
    for (int d = 0; d < 2; d++) begin
      drive_op(d[0], 16'h0F0F, 16'h3C3C, 1, 0, 0, 0);
      checks++; if (obs_key.size() != ROUNDS) begin
        errors++; $display("FAIL key_count_dec%0d: got %0d expected %0d", d, obs_key.size(), ROUNDS);
      end else begin
        l = 16'h0F0F; r = 16'h3C3C;
        for (int k = 0; k < ROUNDS; k++) begin
          ii = (d == 1) ? (ROUNDS - 1 - k) : k;
          ek = ii[IDX_W-1:0];
          checks++; if (obs_key[k] !== ek) begin
            errors++; $display("FAIL key_idx_dec%0d_r%0d: got %0d expected %0d", d, k, obs_key[k], ek);
          end
          checks++; if (obs_fdata[k] !== r) begin
            errors++; $display("FAIL f_data_dec%0d_r%0d: got %h expected %h", d, k, obs_fdata[k], r);
          end
          t = r; r = l ^ f_fn(1, r, ek); l = t;
        end
      end
    end
  endtask

  task automatic test_round_trip();
    logic [31:0] exp;
    logic [15:0] el, er;
    exp = ref_cipher(1'b0, 16'h0F0F, 16'h3C3C, 1);
    drive_op(1'b0, 16'h0F0F, 16'h3C3C, 1, 0, 0, 0);
    el = res_l; er = res_r;
    checks++; if ({el, er} !== exp) begin
      errors++; $display("FAIL rt_encrypt: got %h/%h expected %h/%h", el, er, exp[31:16], exp[15:0]);
    end
    drive_op(1'b1, el, er, 1, 0, 0, 0);
    checks++; if (res_l !== 16'h0F0F || res_r !== 16'h3C3C) begin
      errors++; $display("FAIL rt_decrypt: got %h/%h expected 0f0f/3c3c", res_l, res_r);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp;
    exp = ref_cipher(1'b0, 16'hBEEF, 16'h1357, 1);
    drive_op(1'b0, 16'hBEEF, 16'h1357, 1, 3, 0, 0);
    checks++; if (done_cyc != 33) begin errors++; $display("FAIL wait_done_cycle: got %0d expected 33", done_cyc); end
    checks++; if (unstable) begin errors++; $display("FAIL wait_stable: got unstable expected stable"); end
    checks++; if ({res_l, res_r} !== exp) begin
      errors++; $display("FAIL wait_result: got %h/%h expected %h/%h", res_l, res_r, exp[31:16], exp[15:0]);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wait_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_busy_start();
    logic [31:0] exp;
    exp = ref_cipher(1'b0, 16'h2468, 16'h9ACE, 1);
    drive_op(1'b0, 16'h2468, 16'h9ACE, 1, 0, 3, 0);
    checks++; if ({res_l, res_r} !== exp) begin
      errors++; $display("FAIL busy_result: got %h/%h expected %h/%h", res_l, res_r, exp[31:16], exp[15:0]);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != 9) begin errors++; $display("FAIL busy_done_cycle: got %0d expected 9", done_cyc); end
  endtask

  task automatic test_mid_run_reset();
    logic [31:0] exp;
    int extra_done;
    drive_op(1'b0, 16'h0F0F, 16'h3C3C, 1, 0, 0, 5);
    checks++; if (rs_ready !== 1'b1) begin errors++; $display("FAIL mrr_ready: got %b expected 1", rs_ready); end
    checks++; if (rs_freq !== 1'b0) begin errors++; $display("FAIL mrr_f_req: got %b expected 0", rs_freq); end
    checks++; if (rs_dl !== 16'h0 || rs_dr !== 16'h0) begin
      errors++; $display("FAIL mrr_dout: got %h/%h expected 0000/0000", rs_dl, rs_dr);
    end
    checks++; if (rs_done !== 1'b0 || done_cnt != 0) begin
      errors++; $display("FAIL mrr_done: got %b/%0d expected 0/0", rs_done, done_cnt);
    end
    extra_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1) extra_done++;
      @(negedge clk);
    end
    checks++; if (extra_done != 0) begin errors++; $display("FAIL mrr_late_done: got %0d expected 0", extra_done); end
    exp = ref_cipher(1'b0, 16'h7777, 16'h0123, 1);
    drive_op(1'b0, 16'h7777, 16'h0123, 1, 0, 0, 0);
    checks++; if ({res_l, res_r} !== exp || done_cyc != 9) begin
      errors++; $display("FAIL mrr_fresh_run: got %h/%h cyc %0d expected %h/%h cyc 9",
                         res_l, res_r, done_cyc, exp[31:16], exp[15:0]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; din_left = '0; din_right = '0;
    f_ack = 1'b0; f_result = '0;
    @(negedge clk);
    test_reset();
    test_null_f();
    test_key_order();
    test_round_trip();
    test_wait_states();
    test_busy_start();
    test_mid_run_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/feistel_round_ctrl.md
# feistel_round_ctrl

Round sequencer for a 16+16-bit Feistel cipher. It latches a 32-bit block as left/right halves and iterates ROUNDS rounds through one shared, externally supplied round-function (F) unit using a req/ack handshake. It selects the round-key index for encrypt or decrypt, applies the Feistel update each round, and presents the result with the final-swap convention so that the same hardware decrypts. It sits between the block-level datapath and the F unit / round-key store.

## Interface
Parameters:
- ROUNDS, default 8: number of Feistel rounds. Legal range is 2..256.
- IDX_W, default 3: width of the key index. Must equal clog2(ROUNDS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin operation on the current inputs. Sampled only when ready=1.
- decrypt  in  1  mode. 0 = encrypt, 1 = decrypt. Latched with start.
- din_left  in  16  plaintext/ciphertext left half. Latched with start.
- din_right  in  16  right half. Latched with start.
- ready  out  1  high in IDLE only.
- f_req  out  1  request to the F unit.
- f_data  out  16  F input, equal to the current right half.
- f_key_idx  out  IDX_W  round-key index for the current round.
- f_ack  in  1  F result valid. Meaningful only while f_req=1.
- f_result  in  16  F output. Sampled in the f_ack cycle.
- dout_left  out  16  result left half.
- dout_right  out  16  result right half.
- done  out  1  one-cycle pulse. dout_* are valid from that cycle onward.

## Operation
- Registers:
  - L and R, the block halves.
  - rnd, the round counter, IDX_W+1 bits.
  - mode, the latched decrypt bit.
- States:
  - IDLE: ready=1. When start=1, latch L=din_left, R=din_right, mode=decrypt and rnd=0, then go to RUN.
  - RUN: f_req=1, f_data=R, f_key_idx = mode ? ROUNDS-1-rnd : rnd.
    - On a cycle with f_ack=1: L <= R, R <= L ^ f_result, rnd <= rnd+1.
    - If rnd == ROUNDS-1 at that edge, go to DONE. Otherwise stay in RUN with the new f_data/f_key_idx.
  - DONE: dout_left <= R, dout_right <= L (undoes the last swap). done=1 for this single cycle, then go to IDLE.
- Handshake rules:
  - f_req, f_data and f_key_idx stay stable from the cycle f_req rises until the f_ack cycle.
  - f_ack with f_req=0 is ignored.
  - f_req stays high across back-to-back rounds; it does not drop between rounds.
  - The F unit may hold f_ack low indefinitely. There is no timeout.
- start while not in IDLE is ignored. din_* and decrypt are not re-sampled.
- dout_* hold their value until the next DONE.
- Decryption: feeding dout_left/dout_right back with decrypt=1 and the same key store returns the original din_left/din_right.
- Reset in any state, at the rst edge:
  - state goes to IDLE.
  - f_req, done and f_key_idx go to 0.
  - L, R, rnd, dout_left, dout_right and f_data go to 0.
  - ready goes to 1.
- An operation in flight is abandoned with no done pulse. An f_ack arriving in the reset cycle is discarded.

## Timing
- Reset values:
  - ready=1.
  - f_req=0, done=0.
  - f_data=0, f_key_idx=0.
  - dout_left=0, dout_right=0.
- start accepted at edge T:
  - ready=0 and f_req=1 from cycle T+1.
  - Round k (k=0..ROUNDS-1) completes at the edge of its f_ack cycle.
- Zero-wait F (f_ack held 1): one round per cycle. done is high in cycle T+ROUNDS+1, and ready returns to 1 in cycle T+ROUNDS+2.
- Each cycle f_ack is held low adds one cycle to total latency.
- Earliest next start is sampled in the first cycle ready=1 after done. Throughput at zero wait is one block per ROUNDS+2 cycles.
- All outputs are registered. There are no combinational paths from f_ack/f_result to any output.

## Test plan
- Null F, ROUNDS=8: f_ack=1 and f_result=0 every cycle; start with din_left=0x1234, din_right=0xABCD at edge T -> done only in cycle T+9, dout_left=0xABCD, dout_right=0x1234, ready=1 in cycle T+10.
- Key order: encrypt run -> f_key_idx takes 0,1,...,7 on successive ack cycles. Decrypt run -> 7,6,...,0. f_data matches the model R on every ack.
- Round-trip: F model f_result = (f_data*0x9E37 + 0x1111*f_key_idx) mod 2^16; encrypt din 0x0F0F/0x3C3C, then decrypt the result -> dout_left=0x0F0F, dout_right=0x3C3C. Encrypt output matches the bench reference model.
- Wait states: f_ack asserted 3 cycles after each f_req rise, i.e. 4 cycles per round -> done in cycle T+33; f_data and f_key_idx stable throughout every wait; random f_result on non-ack cycles has no effect.
- Busy start: pulse start with din 0xFFFF/0xFFFF in cycle T+3 of a run -> ignored, result equals the undisturbed run, and no second done.
- Mid-run reset: rst=1 at the edge after round 3 completes -> next cycle ready=1, f_req=0, dout_*=0, no done pulse. A fresh start then completes normally.
